configurable_ring_shift_register: RTL
=====================================

CONFIGURABLE_RING_SHIFT_REGISTER -- requirements
Module: configurable_ring_shift_register

Interface
REQ-001 Parameter WIDTH, default 6: register length in bits, legal range 2..32.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into q on reset, WIDTH bits.
REQ-003 Parameter SELF_CORRECT, default 1: 1 enables illegal-state recovery in twisted modes; 0 disables it.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  advance enable; when 0, all state holds and pulse outputs are 0.
REQ-007 mode  input  3  operation select, see REQ-012.
REQ-008 sin  input  1  serial input for the shift modes.
REQ-009 d  input  WIDTH  parallel load data.
REQ-010 q  output  WIDTH  register contents, registered.
REQ-011 sout  output  1  bit shifted out on the last advance, registered; period_done  output  1  one-cycle pulse, registered; err  output  1  one-cycle pulse, registered.

Function
REQ-012 On a rising clk edge with en=1, q SHALL update per mode:
- 000 hold: q unchanged;
- 001 shift left: {q[W-2:0], sin};
- 010 shift right: {sin, q[W-1:1]};
- 011 rotate left: {q[W-2:0], q[W-1]};
- 100 rotate right: {q[0], q[W-1:1]};
- 101 twisted left: {q[W-2:0], ~q[W-1]};
- 110 twisted right: {~q[0], q[W-1:1]};
- 111 parallel load: d.
REQ-013 sout SHALL take the value of q[W-1] for modes 001/011/101 and q[0] for modes 010/100/110, using the pre-edge value; sout SHALL hold in modes 000 and 111.
REQ-014 A state is a valid Johnson state when the count of i in 0..W-2 with q[i]!=q[i+1] is at most 1.
REQ-015 With SELF_CORRECT=1, en=1, mode 101 or 110, and q not a valid Johnson state, the next q SHALL be all zeros instead of the REQ-012 result.
- err SHALL pulse high for that one cycle, coincident with the corrected q.
- The step counter SHALL clear.
- sout SHALL follow REQ-013.
REQ-016 With SELF_CORRECT=0, no correction occurs and err SHALL remain 0.
REQ-017 Internal step counter: width clog2(2*WIDTH), range 0..2*WIDTH-1.
- Increments on each en=1 cycle in mode 101 or 110.
- Wraps from 2*WIDTH-1 to 0.
REQ-018 The step counter SHALL clear to 0 on any en=1 cycle whose mode is neither 101 nor 110, including hold and parallel load.
- Switching between 101 and 110 SHALL NOT clear the counter.
REQ-019 period_done SHALL pulse high for exactly one cycle, coincident with the q update, on the cycle the counter wraps from 2*WIDTH-1 to 0.
REQ-020 A correction cycle (REQ-015) SHALL NOT assert period_done.
REQ-021 period_done and err SHALL be 0 on every cycle not named in REQ-015/REQ-019, including en=0 cycles.
REQ-022 No combinational path SHALL exist from inputs to any output.

Reset
REQ-023 While reset=1, regardless of clk:
- q SHALL equal RESET_VALUE;
- sout, period_done and err SHALL be 0;
- the step counter SHALL be 0.
REQ-024 Reset asserted mid-sequence SHALL abort the operation immediately; the first en=1 edge after deassertion operates from the reset state.

Verification (WIDTH=6, RESET_VALUE=0, SELF_CORRECT=1 unless stated)
REQ-025 Reset, then mode=101, en=1 for 12 cycles -> q = 000001, 000011, 000111, 001111, 011111, 111111, 111110, 111100, 111000, 110000, 100000, 000000.
- period_done is 1 only on cycle 12.
- err stays 0.
REQ-026 Mode=111, d=101101, then mode=101 for 1 cycle -> q=101101, then q=000000 with err=1 for one cycle.
- Repeat with SELF_CORRECT=0 -> q=011010, err=0.
REQ-027 Load 100000, then mode=011 for 6 cycles -> q walks 000001...100000, returns to 100000, period_done=0.
- Mode=001, sin=1 -> q=000001, sout=1.
REQ-028 Reset, mode=110, en=1 for 5 cycles, then en=0 for 3 cycles, then en=1 for 7 cycles -> q holds 111110 during en=0 (sequence 100000, 110000, 111000, 111100, 111110).
- period_done pulses on the 12th enabled step only.
REQ-029 Mode=101 for 6 cycles (q=111111), assert reset for 1 cycle mid-clock -> q=000000 immediately, step counter 0.
- 12 further mode=101 steps -> period_done on the 12th only.

Source files
------------

// File: rtl/configurable_ring_shift_register.sv
// -----------------------------------------------------------------------------
// configurable_ring_shift_register
//
// Multi-mode shift register: hold, shift left/right, rotate left/right,
// twisted (Johnson) left/right and parallel load. In the twisted modes a step
// counter tracks progress through the 2*WIDTH-state Johnson cycle and pulses
// period_done on wrap. Optional self-correction forces illegal twisted-mode
// states back to all zeros and pulses err.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   en           advance enable (state holds, pulses low when 0)
//   mode[2:0]    operation select
//   sin          serial input for shift modes
//   d[W-1:0]     parallel load data
//   q[W-1:0]     register contents (registered)
//   sout         bit shifted out on the last advance (registered)
//   period_done  one-cycle pulse on Johnson period completion (registered)
//   err          one-cycle pulse on illegal-state correction (registered)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module configurable_ring_shift_register #(
   parameter int               WIDTH        = 6,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter bit               SELF_CORRECT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             period_done,
   output logic             err
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ROL  = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_TWL  = 3'b101;
   localparam logic [2:0] MODE_TWR  = 3'b110;
   localparam logic [2:0] MODE_LOAD = 3'b111;

   localparam int            CW       = $clog2(2 * WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(2 * WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_next;
   logic [WIDTH-1:0] q_next;
   logic             sout_next;
   logic             pd_next;
   logic             err_next;
   logic             twisted;
   logic             johnson_ok;
   int               transitions;

   // A legal Johnson state has at most one boundary between a run of ones and
   // a run of zeros.
   always_comb begin
      transitions = 0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (q[i] != q[i+1]) transitions = transitions + 1;
      end
      johnson_ok = (transitions < 2);
   end

   always_comb begin
      q_next    = q;
      sout_next = sout;
      cnt_next  = '0;
      pd_next   = 1'b0;
      err_next  = 1'b0;
      twisted   = (mode == MODE_TWL) || (mode == MODE_TWR);

      case (mode)
         MODE_HOLD: q_next = q;
         MODE_SHL: begin
            q_next    = {q[WIDTH-2:0], sin};
            sout_next = q[WIDTH-1];
         end
         MODE_SHR: begin
            q_next    = {sin, q[WIDTH-1:1]};
            sout_next = q[0];
         end
         MODE_ROL: begin
            q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
            sout_next = q[WIDTH-1];
         end
         MODE_ROR: begin
            q_next    = {q[0], q[WIDTH-1:1]};
            sout_next = q[0];
         end
         MODE_TWL: begin
            q_next    = {q[WIDTH-2:0], ~q[WIDTH-1]};
            sout_next = q[WIDTH-1];
         end
         MODE_TWR: begin
            q_next    = {~q[0], q[WIDTH-1:1]};
            sout_next = q[0];
         end
         MODE_LOAD: q_next = d;
         default:   q_next = q;
      endcase

      // Correction takes priority over the period wrap so a recovered state
      // never reports a completed period.
      if (twisted) begin
         if (SELF_CORRECT && !johnson_ok) begin
            q_next   = '0;
            cnt_next = '0;
            err_next = 1'b1;
         end else if (cnt == CNT_LAST) begin
            cnt_next = '0;
            pd_next  = 1'b1;
         end else begin
            cnt_next = cnt + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q           <= RESET_VALUE;
         sout        <= 1'b0;
         period_done <= 1'b0;
         err         <= 1'b0;
         cnt         <= '0;
      end else if (en) begin
         q           <= q_next;
         sout        <= sout_next;
         period_done <= pd_next;
         err         <= err_next;
         cnt         <= cnt_next;
      end else begin
         period_done <= 1'b0;
         err         <= 1'b0;
      end
   end

endmodule
